char_stream_normalizer: RTL

- Upstream front-end for the begin/end block checker: accepts raw ASCII bytes under a valid/ready handshake and emits a cleaned character stream.
- Cleaning rules:
  - Letters are lowercased.
  - Every run of non-alphanumeric bytes becomes exactly one space (0x20).
  - Leading separators are dropped.
- Emitted characters go through a small FIFO so the consumer may stall; the block also counts words seen.

---
 rtl/char_stream_normalizer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/char_stream_normalizer.sv
// ---------------------------------------------------------------------------
// char_stream_normalizer
//
// Front-end for the begin/end block checker. Raw ASCII bytes arrive under a
// valid/ready handshake and are cleaned into a character stream:
//   - letters are lowercased,
//   - each run of non-alphanumeric bytes collapses to a single 0x20,
//   - separators before the first word (or after a reset) are dropped.
// Cleaned characters are queued in a small FIFO so the consumer may stall.
// The block also counts the words that have been started.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, 2..16)
//   CNT_W  width of word_count
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_data     raw input byte
//   in_valid    in_data is valid this cycle
//   in_ready    block accepts in_data this cycle
//   flush       end-of-stream request; closes an open word with one space
//   out_data    normalized character at the FIFO head
//   out_valid   out_data is valid
//   out_ready   consumer takes out_data this cycle
//   word_count  words started since reset (saturating)
// ---------------------------------------------------------------------------
module char_stream_normalizer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FC_W  = $clog2(DEPTH) + 1;

    typedef enum logic {
        GAP  = 1'b0,
        WORD = 1'b1
    } state_t;

    // FIFO storage: plain array without reset so it maps onto RAM.
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [FC_W-1:0]  fifo_count_reg;
    logic [7:0]       out_data_reg;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] word_count_reg;

    // Classification and mapping.
    logic       is_upper;
    logic       is_lower;
    logic       is_digit;
    logic       is_word;
    logic [7:0] mapped;

    logic       fifo_full;
    logic       fifo_empty;
    logic       acc;
    logic       pop;
    logic       push;
    logic [7:0] push_data;
    logic       word_inc;

    assign is_upper = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign is_lower = (in_data >= 8'h61) && (in_data <= 8'h7A);
    assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    assign is_word  = is_upper || is_lower || is_digit;
    assign mapped   = is_upper ? (in_data | 8'h20) : in_data;

    assign fifo_full  = (fifo_count_reg == FC_W'(DEPTH));
    assign fifo_empty = (fifo_count_reg == '0);

    // No fall-through when full: a pop in the same cycle does not open a slot
    // for the incoming byte.
    assign in_ready = !fifo_full && !flush;
    assign acc      = in_valid && in_ready;
    assign pop      = !fifo_empty && out_ready;

    assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

    // Next-state / push decision. flush forces in_ready low, so acc and the
    // flush close-out can never coincide.
    always_comb begin
        push       = 1'b0;
        push_data  = mapped;
        state_next = state_reg;
        word_inc   = 1'b0;
        case (state_reg)
            GAP: begin
                if (acc && is_word) begin
                    push       = 1'b1;
                    word_inc   = 1'b1;
                    state_next = WORD;
                end
            end
            WORD: begin
                if (acc) begin
                    push = 1'b1;
                    if (!is_word) begin
                        push_data  = 8'h20;
                        state_next = GAP;
                    end
                end else if (flush && !fifo_full) begin
                    // Close the open word; once in GAP a held flush is inert.
                    push       = 1'b1;
                    push_data  = 8'h20;
                    state_next = GAP;
                end
            end
            default: state_next = GAP;
        endcase
    end

    // FIFO write port.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Control state, counters and the registered head-of-FIFO output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= GAP;
            word_count_reg <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
            out_data_reg   <= 8'h00;
        end else begin
            state_reg <= state_next;

            if (word_inc && (word_count_reg != {CNT_W{1'b1}})) begin
                word_count_reg <= word_count_reg + CNT_W'(1);
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end

            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + FC_W'(1);
                2'b01:   fifo_count_reg <= fifo_count_reg - FC_W'(1);
                default: fifo_count_reg <= fifo_count_reg;
            endcase

            // Head register: the new head is either the byte being pushed into
            // an empty (or emptying) FIFO, or the entry behind the popped one.
            // Otherwise it holds, which keeps the last value when empty.
            if (push && (fifo_empty || (pop && fifo_count_reg == FC_W'(1)))) begin
                out_data_reg <= push_data;
            end else if (pop && (fifo_count_reg > FC_W'(1))) begin
                out_data_reg <= mem[rd_ptr_inc];
            end
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = !fifo_empty;
    assign word_count = word_count_reg;

endmodule
